// File: rtl/diff_operator_mc.sv
`default_nettype none
// ============================================================================
// diff_operator_mc : backward differences of orders 1..MAX_ORDER on N_CH streams
// Revision: 1.0
// ============================================================================
module diff_operator_mc #(
  parameter int DATA_W    = 16,
  parameter int MAX_ORDER = 3,
  parameter int N_CH      = 2,
  parameter int SATURATE  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               en,
  input  logic                               clr,
  input  logic [N_CH*DATA_W-1:0]             y,
  output logic [N_CH*MAX_ORDER*DATA_W-1:0]   out,
  output logic                               out_valid,
  output logic [MAX_ORDER-1:0]               order_valid,
  output logic [N_CH-1:0]                    sat_flag
);

  localparam int FW    = DATA_W + MAX_ORDER;
  localparam int CNT_W = $clog2(MAX_ORDER + 2);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(MAX_ORDER + 1);
  localparam logic signed [FW-1:0] MAX_V   = {{(MAX_ORDER+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [FW-1:0] MIN_V   = {{(MAX_ORDER+1){1'b1}}, {(DATA_W-1){1'b0}}};

  function automatic logic out_of_range(input logic signed [FW-1:0] v);
    return (v > MAX_V) || (v < MIN_V);
  endfunction

  function automatic logic [DATA_W-1:0] shape(input logic signed [FW-1:0] v);
    logic [DATA_W-1:0] r;
    r = v[DATA_W-1:0];
    if (SATURATE != 0) begin
      if (v > MAX_V)      r = MAX_V[DATA_W-1:0];
      else if (v < MIN_V) r = MIN_V[DATA_W-1:0];
    end
    return r;
  endfunction

  logic [CNT_W-1:0]     count_q, count_d;
  logic [MAX_ORDER-1:0] order_valid_q, order_valid_d;
  logic                 out_valid_q, out_valid_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en && count_q != CNT_MAX)
      count_d = count_q + 1'b1;
    // order k needs k+1 samples of history
    order_valid_d = '0;
    for (int k = 0; k < MAX_ORDER; k++)
      order_valid_d[k] = (int'(count_d) >= k + 2);
    out_valid_d = en && !clr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q       <= '0;
      order_valid_q <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      count_q       <= count_d;
      order_valid_q <= order_valid_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign order_valid = order_valid_q;
  assign out_valid   = out_valid_q;

  genvar c;
  generate
    for (c = 0; c < N_CH; c++) begin : g_ch
      logic signed [FW-1:0]        prev_q [MAX_ORDER];
      logic signed [FW-1:0]        prev_d [MAX_ORDER];
      logic signed [FW-1:0]        diff   [MAX_ORDER+1];
      logic [MAX_ORDER*DATA_W-1:0] out_q, out_d;
      logic                        sat_q, sat_d;

      always_comb begin
        diff[0] = {{MAX_ORDER{y[c*DATA_W+DATA_W-1]}}, y[c*DATA_W +: DATA_W]};
        for (int k = 1; k <= MAX_ORDER; k++)
          diff[k] = diff[k-1] - prev_q[k-1];
        prev_d = prev_q;
        out_d  = out_q;
        sat_d  = sat_q;
        if (clr) begin
          for (int k = 0; k < MAX_ORDER; k++)
            prev_d[k] = '0;
          out_d = '0;
          sat_d = 1'b0;
        end else if (en) begin
          for (int k = 0; k < MAX_ORDER; k++) begin
            prev_d[k] = diff[k];
            out_d[k*DATA_W +: DATA_W] = '0;
            if (order_valid_d[k]) begin
              out_d[k*DATA_W +: DATA_W] = shape(diff[k+1]);
              if (out_of_range(diff[k+1]))
                sat_d = 1'b1;
            end
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < MAX_ORDER; k++)
            prev_q[k] <= '0;
          out_q <= '0;
          sat_q <= 1'b0;
        end else begin
          prev_q <= prev_d;
          out_q  <= out_d;
          sat_q  <= sat_d;
        end
      end

      assign out[c*MAX_ORDER*DATA_W +: MAX_ORDER*DATA_W] = out_q;
      assign sat_flag[c] = sat_q;
    end
  endgenerate

endmodule
`default_nettype wire
